// File: rtl/cim_job_sched_pkg.sv
// Shared types and constants for the CIM job scheduler.
// Holds the scheduler state encoding, default pass lengths and port widths.
package cim_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } sched_state_e;

  localparam int N_LO_DEF     = 12;
  localparam int N_HI_DEF     = 24;
  localparam int PIPE_LAT_DEF = 2;
  localparam int ACC_W_DEF    = 51;
  localparam int XIN_W        = 96;
  localparam int D_W          = 24;
  localparam int WA_W         = 8;
  localparam int ADDR_W       = 3;
  localparam int RUN_CNT_W    = 6;

  function automatic logic [WA_W-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
    logic [WA_W-1:0] v;
    v = {{(WA_W-1){1'b0}}, 1'b1} << addr;
    return v;
  endfunction

endpackage

// File: rtl/cim_bank_tracker.sv
// Tracks which macro row computes, whether each row holds weights,
// and drives the registered word-line write port into the shadow row.
module cim_bank_tracker
  import cim_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [D_W-1:0]    i_wr_data,
  input  logic              i_wr_last,
  input  logic              i_swap,
  output logic              o_wr_ready,
  output logic              o_cbank,
  output logic              o_cur_valid,
  output logic              o_sh_full,
  output logic [WA_W-1:0]   o_wa,
  output logic [D_W-1:0]    o_d
);

  logic            r_wr_ready;
  logic            r_cbank;
  logic            r_cur_valid;
  logic            r_sh_full;
  logic [WA_W-1:0] r_wa;
  logic [D_W-1:0]  r_d;
  logic            w_wr_fire;
  logic            w_sh_full_nxt;

  assign w_wr_fire = i_wr_valid & r_wr_ready;

  // Shadow row becomes full on the last word and empties when it is swapped in.
  always_comb begin
    w_sh_full_nxt = r_sh_full;
    if (w_wr_fire && i_wr_last) begin
      w_sh_full_nxt = 1'b1;
    end else if (i_swap) begin
      w_sh_full_nxt = 1'b0;
    end else begin
      w_sh_full_nxt = r_sh_full;
    end
  end

  // Bank flags and write port; ready is looked ahead so it drops the cycle after wr_last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ready  <= 1'b0;
      r_cbank     <= 1'b0;
      r_cur_valid <= 1'b0;
      r_sh_full   <= 1'b0;
      r_wa        <= {WA_W{1'b0}};
      r_d         <= {D_W{1'b0}};
    end else begin
      r_wr_ready <= ~w_sh_full_nxt & ~i_swap;
      r_sh_full  <= w_sh_full_nxt;
      if (i_swap) begin
        r_cbank     <= ~r_cbank;
        r_cur_valid <= 1'b1;
      end
      if (w_wr_fire) begin
        r_wa <= addr_onehot(i_wr_addr);
        r_d  <= i_wr_data;
      end else begin
        r_wa <= {WA_W{1'b0}};
      end
    end
  end

  assign o_wr_ready  = r_wr_ready;
  assign o_cbank     = r_cbank;
  assign o_cur_valid = r_cur_valid;
  assign o_sh_full   = r_sh_full;
  assign o_wa        = r_wa;
  assign o_d         = r_d;

endmodule

// File: rtl/cim_job_sched.sv
// Serialises MAC jobs onto the CIM macro: aligns each pass to st, drains the
// accumulator pipeline and returns the result over a valid/ready port.
module cim_job_sched
  import cim_sched_pkg::*;
#(
  parameter int N_LO     = N_LO_DEF,
  parameter int N_HI     = N_HI_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [D_W-1:0]    wr_data,
  input  logic              wr_last,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic              job_inwidth,
  input  logic              job_wwidth,
  input  logic              job_swap,
  input  logic [XIN_W-1:0]  job_xin,
  input  logic              st,
  input  logic [ACC_W-1:0]  nout,
  output logic              cima,
  output logic              acm_en,
  output logic              inwidth,
  output logic              wwidth,
  output logic [XIN_W-1:0]  xin0,
  output logic [WA_W-1:0]   WA,
  output logic [D_W-1:0]    D,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy
);

  localparam int DR_W = $clog2(PIPE_LAT + 1);

  sched_state_e           r_state;
  sched_state_e           w_state_nxt;
  logic [RUN_CNT_W-1:0]   r_run_cnt;
  logic [DR_W-1:0]        r_dr_cnt;
  logic                   r_acm_en;
  logic                   r_res_valid;
  logic                   r_busy;
  logic                   r_inwidth;
  logic                   r_wwidth;
  logic [XIN_W-1:0]       r_xin;
  logic [ACC_W-1:0]       r_res_data;
  logic                   w_cbank;
  logic                   w_cur_valid;
  logic                   w_sh_full;
  logic                   w_job_ready;
  logic                   w_job_fire;
  logic                   w_swap;
  logic                   w_run_last;
  logic                   w_dr_last;

  assign w_job_ready = (r_state == ST_IDLE) & (job_swap ? w_sh_full : w_cur_valid);
  assign w_job_fire  = job_valid & w_job_ready;
  assign w_swap      = w_job_fire & job_swap;
  assign w_run_last  = r_run_cnt == (r_inwidth ? RUN_CNT_W'(N_HI - 1) : RUN_CNT_W'(N_LO - 1));
  assign w_dr_last   = r_dr_cnt == DR_W'(PIPE_LAT - 1);

  cim_bank_tracker u_bank (
    .clk        (clk),
    .rstn       (rstn),
    .i_wr_valid (wr_valid),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_wr_last  (wr_last),
    .i_swap     (w_swap),
    .o_wr_ready (wr_ready),
    .o_cbank    (w_cbank),
    .o_cur_valid(w_cur_valid),
    .o_sh_full  (w_sh_full),
    .o_wa       (WA),
    .o_d        (D)
  );

  // Next-state decode; st seen in ARM starts the pass on the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_job_fire) w_state_nxt = ST_ARM;   else w_state_nxt = ST_IDLE;
      ST_ARM:   if (st)         w_state_nxt = ST_RUN;   else w_state_nxt = ST_ARM;
      ST_RUN:   if (w_run_last) w_state_nxt = ST_DRAIN; else w_state_nxt = ST_RUN;
      ST_DRAIN: if (w_dr_last)  w_state_nxt = ST_HOLD;  else w_state_nxt = ST_DRAIN;
      ST_HOLD:  if (res_ready)  w_state_nxt = ST_IDLE;  else w_state_nxt = ST_HOLD;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_acm_en    <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acm_en    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_res_valid <= w_state_nxt == ST_HOLD;
      r_busy      <= w_state_nxt != ST_IDLE;
    end
  end

  // Pass counters, job configuration capture and result capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run_cnt  <= {RUN_CNT_W{1'b0}};
      r_dr_cnt   <= {DR_W{1'b0}};
      r_inwidth  <= 1'b0;
      r_wwidth   <= 1'b0;
      r_xin      <= {XIN_W{1'b0}};
      r_res_data <= {ACC_W{1'b0}};
    end else begin
      r_run_cnt <= (r_state == ST_RUN)   ? r_run_cnt + RUN_CNT_W'(1) : {RUN_CNT_W{1'b0}};
      r_dr_cnt  <= (r_state == ST_DRAIN) ? r_dr_cnt + DR_W'(1)       : {DR_W{1'b0}};
      if (w_job_fire) begin
        r_inwidth <= job_inwidth;
        r_wwidth  <= job_wwidth;
        r_xin     <= job_xin;
      end
      if ((r_state == ST_DRAIN) && w_dr_last) begin
        r_res_data <= nout;
      end
    end
  end

  assign job_ready = w_job_ready;
  assign cima      = w_cbank;
  assign acm_en    = r_acm_en;
  assign inwidth   = r_inwidth;
  assign wwidth    = r_wwidth;
  assign xin0      = r_xin;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cim_job_sched.sv
// Randomised scoreboard bench for cim_job_sched: drivers push expected
// write pulses and job results, a negedge monitor pops and compares.
module tb_cim_job_sched;
  localparam int N_LO = 12;
  localparam int N_HI = 24;
  localparam int PL   = 2;
  localparam int AW   = 51;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic wr_valid = 1'b0, wr_last = 1'b0, wr_ready;
  logic [2:0] wr_addr = 3'd0;
  logic [23:0] wr_data = 24'd0;
  logic job_valid = 1'b0, job_ready, job_inwidth = 1'b0, job_wwidth = 1'b0, job_swap = 1'b0;
  logic [95:0] job_xin = 96'd0;
  logic st = 1'b0;
  logic [AW-1:0] nout = '0;
  logic cima, acm_en, inwidth, wwidth, res_valid, busy;
  logic res_ready = 1'b1;
  logic [95:0] xin0;
  logic [7:0] WA;
  logic [23:0] D;
  logic [AW-1:0] res_data;

  always #5 clk = ~clk;

  cim_job_sched #(.N_LO(N_LO), .N_HI(N_HI), .PIPE_LAT(PL), .ACC_W(AW)) dut (
    .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last), .job_valid(job_valid), .job_ready(job_ready),
    .job_inwidth(job_inwidth), .job_wwidth(job_wwidth), .job_swap(job_swap), .job_xin(job_xin),
    .st(st), .nout(nout), .cima(cima), .acm_en(acm_en), .inwidth(inwidth), .wwidth(wwidth),
    .xin0(xin0), .WA(WA), .D(D), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  typedef struct { int a; int t_run; int n; logic [AW-1:0] data; logic [95:0] xin; logic iw; logic ww; } job_t;
  typedef struct { logic [2:0] addr; logic [23:0] data; logic bank; } wr_t;

  job_t jq[$];
  wr_t  wq[$];
  int cyc = 0, st_per = 12, st_ph = 5;
  int errors = 0, checks = 0, done_cnt = 0, g_trun = 0;
  logic m_cbank = 1'b0;
  bit rr_rand = 1'b0;
  logic rr_fix = 1'b1;

  // Macro accumulator stand-in: a distinct pseudo-random value every cycle.
  function automatic logic [AW-1:0] nf(input int k);
    logic [63:0] v;
    v = {32'(k), 32'(k) * 32'h9E3779B1};
    return v[AW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      st = ((cyc % st_per) == st_ph);
      nout = nf(cyc);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fix;
    end
  end

  int m_k;
  job_t m_h;
  wr_t m_w;
  bit m_rise, pv, pr;
  logic [AW-1:0] pd;

  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      m_k = cyc;
      m_rise = 1'b0;
      if (WA != 8'd0) begin
        if (wq.size() == 0) chk("wa_unexpected", WA, 8'd0);
        else begin
          m_w = wq.pop_front();
          chk("wa_onehot", WA, 8'd1 << m_w.addr);
          chk("wr_data", D, m_w.data);
          chk("wr_cima", cima, m_w.bank);
        end
      end
      if (jq.size() > 0) begin
        m_h = jq[0];
        if (m_k >= m_h.a + 1) begin
          chk("xin0", xin0, m_h.xin);
          chk("inwidth", inwidth, m_h.iw);
          chk("wwidth", wwidth, m_h.ww);
          chk("busy", busy, 1'b1);
        end
        chk("acm_en", acm_en, (m_k >= m_h.t_run) && (m_k < m_h.t_run + m_h.n + PL));
        if (m_k == m_h.t_run + m_h.n + PL) begin
          m_rise = 1'b1;
          chk("res_valid_latency", res_valid, 1'b1);
          chk("res_data", res_data, m_h.data);
          void'(jq.pop_front());
        end
      end else begin
        chk("acm_en_idle", acm_en, 1'b0);
      end
      if (res_valid && !pv && !m_rise) chk("res_valid_unexpected", res_valid, 1'b0);
      if (pv && !pr) begin
        chk("res_hold_valid", res_valid, 1'b1);
        chk("res_hold_data", res_data, pd);
      end
      if (pv && pr) chk("res_valid_after_hs", res_valid, 1'b0);
      if (res_valid) chk("job_ready_in_hold", job_ready, 1'b0);
      if (res_valid && res_ready) done_cnt++;
      pv = res_valid;
      pr = res_ready;
      pd = res_data;
    end
  end

  task automatic write_word(input logic [2:0] ad, input logic [23:0] dt, input logic last);
    int t = 0;
    wr_t w;
    wr_valid = 1'b1; wr_addr = ad; wr_data = dt; wr_last = last;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      t++;
      if (t > 300) break;
    end
    if (wr_ready) begin
      w.addr = ad; w.data = dt; w.bank = m_cbank;
      wq.push_back(w);
    end else chk("wr_accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #2;
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic load_row(input bit rnd);
    for (int i = 0; i < 8; i++)
      write_word(rnd ? 3'($urandom_range(0, 7)) : 3'(i), 24'($urandom), i == 7);
  endtask

  task automatic run_job(input logic sw, input logic iw, input logic ww, input logic [95:0] xin, input bit wait_done);
    int t, a, r, c, tgt;
    job_t j;
    logic oldb;
    tgt = done_cnt + 1;
    job_valid = 1'b1; job_swap = sw; job_inwidth = iw; job_wwidth = ww; job_xin = xin;
    t = 0;
    forever begin
      @(negedge clk);
      if (job_ready) break;
      t++;
      if (t > 300) break;
    end
    if (!job_ready) begin
      chk("job_accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #2;
      job_valid = 1'b0;
      return;
    end
    a = cyc;
    r = (a + 1) % st_per;
    c = a + 1 + ((st_ph - r + st_per) % st_per);
    j.a = a; j.t_run = c + 1; j.n = iw ? N_HI : N_LO;
    j.data = nf(c + j.n + PL); j.xin = xin; j.iw = iw; j.ww = ww;
    jq.push_back(j);
    g_trun = j.t_run;
    oldb = m_cbank;
    if (sw) m_cbank = ~m_cbank;
    chk("cima_at_accept", cima, oldb);
    @(posedge clk);
    #2;
    job_valid = 1'b0;
    @(negedge clk);
    chk("cima_after_accept", cima, m_cbank);
    @(posedge clk);
    #2;
    if (wait_done) begin
      t = 0;
      while (done_cnt < tgt && t < 400) begin step(); t++; end
      chk("job_done_timeout", done_cnt >= tgt, 1'b1);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_cima", cima, 1'b0);       chk("rst_acm_en", acm_en, 1'b0);
    chk("rst_inwidth", inwidth, 1'b0); chk("rst_wwidth", wwidth, 1'b0);
    chk("rst_xin0", xin0, 96'd0);      chk("rst_wa", WA, 8'd0);
    chk("rst_d", D, 24'd0);            chk("rst_res_data", res_data, '0);
    chk("rst_res_valid", res_valid, 1'b0); chk("rst_busy", busy, 1'b0);
    chk("rst_job_ready", job_ready, 1'b0); chk("rst_wr_ready", wr_ready, 1'b0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("wr_ready_at_release", wr_ready, 1'b0);
    @(posedge clk);
    #2;
    chk("wr_ready_after_release", wr_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tg, t;
    #3;
    job_swap = 1'b1;
    chk_reset_outs();
    release_reset();

    // A non-swap job cannot start before any row is loaded.
    job_valid = 1'b1; job_swap = 1'b0;
    repeat (20) begin @(negedge clk); chk("job_ready_noswap_after_reset", job_ready, 1'b0); end
    step();
    job_valid = 1'b0;

    st_per = 12; st_ph = 5; step();
    load_row(1'b0);
    run_job(1'b1, 1'b0, 1'($urandom_range(0, 1)), {96{1'b1}}, 1'b1);

    // Result held under back-pressure for 10 cycles.
    rr_fix = 1'b0;
    tg = done_cnt + 1;
    run_job(1'b0, 1'b0, 1'b1, {$urandom, $urandom, $urandom}, 1'b0);
    t = 0;
    while (!res_valid && t < 200) begin step(); t++; end
    chk("hold_res_seen", res_valid, 1'b1);
    repeat (10) step();
    rr_fix = 1'b1;
    t = 0;
    while (done_cnt < tg && t < 50) begin step(); t++; end
    chk("hold_done", done_cnt >= tg, 1'b1);

    // Shadow load overlapping a wide pass, then swap it in.
    st_per = 1; st_ph = 0; step();
    fork
      run_job(1'b0, 1'b1, 1'b0, {$urandom, $urandom, $urandom}, 1'b1);
      begin
        repeat (3) step();
        load_row(1'b1);
        @(negedge clk);
        chk("load_done_in_run", acm_en, 1'b1);
        chk("cima_during_load", cima, m_cbank);
        step();
      end
    join
    st_per = 7; st_ph = 3; step();
    run_job(1'b1, 1'b0, 1'b1, {$urandom, $urandom, $urandom}, 1'b1);

    rr_rand = 1'b1;
    for (int it = 0; it < 10; it++) begin
      logic sw;
      st_per = $urandom_range(1, 20);
      st_ph = $urandom_range(0, st_per - 1);
      step();
      sw = ($urandom_range(0, 1) == 1);
      if (sw) load_row(1'b1);
      run_job(sw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, 1'b1);
    end

    // Reset in RUN cycle 5 discards everything.
    rr_rand = 1'b0; rr_fix = 1'b1;
    st_per = 4; st_ph = 1; step();
    load_row(1'b1);
    run_job(1'b1, 1'b1, 1'b1, {$urandom, $urandom, $urandom}, 1'b0);
    t = 0;
    while (cyc < g_trun + 5 && t < 100) begin step(); t++; end
    chk("acm_en_before_reset", acm_en, 1'b1);
    rstn = 1'b0;
    jq.delete(); wq.delete(); m_cbank = 1'b0;
    #1;
    chk_reset_outs();
    release_reset();

    st_per = 5; st_ph = 2; step();
    load_row(1'b0);
    run_job(1'b1, 1'b0, 1'b0, {$urandom, $urandom, $urandom}, 1'b1);
    repeat (3) step();
    chk("job_queue_empty", jq.size(), 0);
    chk("wr_queue_empty", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
